// File: rtl/uc_pkg.sv
// Shared types and encodings for the uc_multiciclo control unit:
// FSM state encoding, opcode class/condition codes and small decode helpers.
package uc_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        CMP   = 3'd2,
        SKIP  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [1:0] CLS_JR   = 2'b00;
    localparam logic [1:0] CLS_LI   = 2'b01;
    localparam logic [1:0] CLS_SKIP = 2'b10;
    localparam logic [1:0] CLS_ALU  = 2'b11;

    localparam logic [1:0] CC_EQ = 2'b00;
    localparam logic [1:0] CC_NE = 2'b01;
    localparam logic [1:0] CC_GT = 2'b10;
    localparam logic [1:0] CC_LT = 2'b11;

    localparam logic [1:0] HALT_SUB = 2'b11;

    // Halt shares the skip class; bits [3:2] distinguish it from the compares.
    function automatic logic is_halt(input logic [1:0] cls, input logic [1:0] sub);
        return (cls == CLS_SKIP) && (sub == HALT_SUB);
    endfunction

    function automatic logic is_skip(input logic [1:0] cls, input logic [1:0] sub);
        return (cls == CLS_SKIP) && (sub != HALT_SUB);
    endfunction

    function automatic logic cond_met(input logic [1:0] cc, input logic zero, input logic carry);
        logic res;
        case (cc)
            CC_EQ:   res = zero;
            CC_NE:   res = !zero;
            CC_GT:   res = !zero && !carry;
            CC_LT:   res = carry;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Moore output decoder: maps the current state and latched instruction to the
// datapath control bundle. Purely combinational, no primary inputs reach it.
module uc_decode
    import uc_pkg::*;
#(
    parameter int                 OPCODE_W = 6,
    parameter int                 ALUOP_W  = 3,
    parameter logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3)
) (
    input  state_t              state,
    input  logic [OPCODE_W-1:0] ir,
    input  logic                skip_flag,
    output logic                pc_we,
    output logic                s_inc,
    output logic                s_skip,
    output logic                s_inm,
    output logic                we,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                halted
);

    logic [1:0] cls;
    assign cls = ir[OPCODE_W-1 -: 2];

    // A halt reaching EXEC falls through the class case and drives nothing.
    always_comb begin
        pc_we  = 1'b0;
        s_inc  = 1'b0;
        s_skip = 1'b0;
        s_inm  = 1'b0;
        we     = 1'b0;
        alu_op = '0;
        halted = 1'b0;
        case (state)
            EXEC: begin
                case (cls)
                    CLS_JR: begin
                        pc_we = 1'b1;
                    end
                    CLS_LI: begin
                        pc_we = 1'b1;
                        s_inc = 1'b1;
                        s_inm = 1'b1;
                        we    = 1'b1;
                    end
                    CLS_ALU: begin
                        pc_we  = 1'b1;
                        s_inc  = 1'b1;
                        we     = 1'b1;
                        alu_op = ir[ALUOP_W-1:0];
                    end
                    default: begin
                        pc_we = 1'b0;
                    end
                endcase
            end
            CMP: begin
                alu_op = ALU_SUB;
            end
            SKIP: begin
                pc_we  = 1'b1;
                s_inc  = 1'b1;
                s_skip = skip_flag;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the microc datapath: instruction FSM, registered
// skip decision and saturating retired-instruction counter.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int                 OPCODE_W = 6,
    parameter int                 ALUOP_W  = 3,
    parameter int                 CNT_W    = 16,
    parameter logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                zero,
    input  logic                carry,
    output logic                pc_we,
    output logic                s_inc,
    output logic                s_skip,
    output logic                s_inm,
    output logic                we,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    state_t              state;
    logic [OPCODE_W-1:0] ir;
    logic                skip_flag;

    logic [1:0] op_cls;
    logic [1:0] op_sub;
    logic [1:0] ir_cls;
    logic [1:0] ir_sub;
    logic       retire_now;

    assign op_cls     = Opcode[OPCODE_W-1 -: 2];
    assign op_sub     = Opcode[3:2];
    assign ir_cls     = ir[OPCODE_W-1 -: 2];
    assign ir_sub     = ir[3:2];
    assign retire_now = (state == EXEC) || (state == SKIP);

    // Opcode is only captured in FETCH; every later state works from ir, so
    // input changes mid-instruction cannot disturb the one in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            ir        <= '0;
            skip_flag <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (run) begin
                        ir    <= Opcode;
                        state <= is_skip(op_cls, op_sub) ? CMP : EXEC;
                    end
                end
                EXEC: begin
                    state <= is_halt(ir_cls, ir_sub) ? HALT : FETCH;
                end
                CMP: begin
                    skip_flag <= cond_met(ir[1:0], zero, carry);
                    state     <= SKIP;
                end
                SKIP: begin
                    state <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Counts on the final cycle of each instruction and sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (retire_now && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_W'(1);
        end
    end

    uc_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W),
        .ALU_SUB  (ALU_SUB)
    ) u_decode (
        .state     (state),
        .ir        (ir),
        .skip_flag (skip_flag),
        .pc_we     (pc_we),
        .s_inc     (s_inc),
        .s_skip    (s_skip),
        .s_inm     (s_inm),
        .we        (we),
        .alu_op    (ALUOp),
        .halted    (halted)
    );

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed testbench for uc_multiciclo: default instance for sequencing checks,
// a CNT_W=2 instance for counter saturation.
module tb_uc_multiciclo;

    logic        clk;
    logic        reset;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        carry;
    logic        pc_we, s_inc, s_skip, s_inm, we, halted;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    logic        run2;
    logic [5:0]  opcode2;
    logic        pc_we2, s_inc2, s_skip2, s_inm2, we2, halted2;
    logic [2:0]  alu_op2;
    logic [1:0]  retired2;

    int total;
    int bad;
    int exp_ret;

    // {pc_we, s_inc, s_skip, s_inm, we, ALUOp[2:0], halted}
    logic [8:0] ctl;
    assign ctl = {pc_we, s_inc, s_skip, s_inm, we, alu_op, halted};

    uc_multiciclo dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .Opcode  (opcode),
        .zero    (zero),
        .carry   (carry),
        .pc_we   (pc_we),
        .s_inc   (s_inc),
        .s_skip  (s_skip),
        .s_inm   (s_inm),
        .we      (we),
        .ALUOp   (alu_op),
        .halted  (halted),
        .retired (retired)
    );

    uc_multiciclo #(.CNT_W(2)) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .run     (run2),
        .Opcode  (opcode2),
        .zero    (zero),
        .carry   (carry),
        .pc_we   (pc_we2),
        .s_inc   (s_inc2),
        .s_skip  (s_skip2),
        .s_inm   (s_inm2),
        .we      (we2),
        .ALUOp   (alu_op2),
        .halted  (halted2),
        .retired (retired2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        run    = 1'b0;
        opcode = 6'b0;
        zero   = 1'b0;
        carry  = 1'b0;
        run2   = 1'b0;
        opcode2 = 6'b0;
        #12;
        total++;
        if (ctl !== 9'b0) begin
            $display("[TB] FAIL reset_ctl: got %b want %b", ctl, 9'b0);
            bad++;
        end
        total++;
        if (retired !== 16'd0) begin
            $display("[TB] FAIL reset_retired: got %0d want 0", retired);
            bad++;
        end
        total++;
        if ({pc_we2, we2, halted2, retired2} !== 5'b0) begin
            $display("[TB] FAIL reset_sat: got %b want 00000", {pc_we2, we2, halted2, retired2});
            bad++;
        end
        reset   = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_li();
        run    = 1'b1;
        opcode = 6'b010100;
        cycle();
        total++;
        if (ctl !== 9'b1_1_0_1_1_000_0) begin
            $display("[TB] FAIL li_exec: got %b want %b", ctl, 9'b1_1_0_1_1_000_0);
            bad++;
        end
        run = 1'b0;
        cycle();
        exp_ret++;
        total++;
        if (ctl !== 9'b0 || retired !== 16'(exp_ret)) begin
            $display("[TB] FAIL li_done: got ctl=%b ret=%0d want ctl=0 ret=%0d", ctl, retired, exp_ret);
            bad++;
        end
    endtask

    task automatic test_alu_jr();
        run    = 1'b1;
        opcode = 6'b110010;
        cycle();
        total++;
        if (ctl !== 9'b1_1_0_0_1_010_0) begin
            $display("[TB] FAIL alu_exec: got %b want %b", ctl, 9'b1_1_0_0_1_010_0);
            bad++;
        end
        opcode = 6'b000000;
        cycle();
        exp_ret++;
        total++;
        if (ctl !== 9'b0) begin
            $display("[TB] FAIL b2b_fetch: got %b want 0", ctl);
            bad++;
        end
        cycle();
        total++;
        if (ctl !== 9'b1_0_0_0_0_000_0) begin
            $display("[TB] FAIL jr_exec: got %b want %b", ctl, 9'b1_0_0_0_0_000_0);
            bad++;
        end
        run = 1'b0;
        cycle();
        exp_ret++;
        total++;
        if (retired !== 16'(exp_ret)) begin
            $display("[TB] FAIL alu_jr_retired: got %0d want %0d", retired, exp_ret);
            bad++;
        end
    endtask

    // Opcode is scrambled and run dropped during CMP; SKIP must still follow ir.
    task automatic test_skip(input logic [5:0] op, input logic z, input logic c,
                             input logic exp_skip, input string name);
        run    = 1'b1;
        opcode = op;
        zero   = z;
        carry  = c;
        cycle();
        total++;
        if (ctl !== 9'b0_0_0_0_0_011_0) begin
            $display("[TB] FAIL %s_cmp: got %b want %b", name, ctl, 9'b0_0_0_0_0_011_0);
            bad++;
        end
        run    = 1'b0;
        opcode = ~op;
        cycle();
        total++;
        if (ctl !== {1'b1, 1'b1, exp_skip, 6'b0}) begin
            $display("[TB] FAIL %s_skip: got %b want %b", name, ctl, {1'b1, 1'b1, exp_skip, 6'b0});
            bad++;
        end
        zero  = 1'b0;
        carry = 1'b0;
        cycle();
        exp_ret++;
        total++;
        if (ctl !== 9'b0 || retired !== 16'(exp_ret)) begin
            $display("[TB] FAIL %s_done: got ctl=%b ret=%0d want ctl=0 ret=%0d", name, ctl, retired, exp_ret);
            bad++;
        end
    endtask

    task automatic test_idle();
        run    = 1'b0;
        opcode = 6'b110111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (ctl !== 9'b0 || retired !== 16'(exp_ret)) begin
                $display("[TB] FAIL idle_%0d: got ctl=%b ret=%0d want ctl=0 ret=%0d", i, ctl, retired, exp_ret);
                bad++;
            end
        end
    endtask

    task automatic test_halt();
        run    = 1'b1;
        opcode = 6'b101100;
        cycle();
        total++;
        if (ctl !== 9'b0) begin
            $display("[TB] FAIL halt_exec: got %b want 0", ctl);
            bad++;
        end
        opcode = 6'b010100;
        cycle();
        exp_ret++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ctl !== 9'b0_0_0_0_0_000_1 || retired !== 16'(exp_ret)) begin
                $display("[TB] FAIL halt_hold_%0d: got ctl=%b ret=%0d want ctl=%b ret=%0d",
                         i, ctl, retired, 9'b0_0_0_0_0_000_1, exp_ret);
                bad++;
            end
            cycle();
        end
        run = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (ctl !== 9'b0 || retired !== 16'd0) begin
            $display("[TB] FAIL halt_reset: got ctl=%b ret=%0d want ctl=0 ret=0", ctl, retired);
            bad++;
        end
        #2 reset = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_reset_mid_cmp();
        run    = 1'b1;
        opcode = 6'b100001;
        zero   = 1'b0;
        cycle();
        total++;
        if (ctl !== 9'b0_0_0_0_0_011_0) begin
            $display("[TB] FAIL mid_cmp: got %b want %b", ctl, 9'b0_0_0_0_0_011_0);
            bad++;
        end
        run = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++;
        if (ctl !== 9'b0) begin
            $display("[TB] FAIL mid_abort: got %b want 0", ctl);
            bad++;
        end
        cycle();
        total++;
        if (ctl !== 9'b0) begin
            $display("[TB] FAIL mid_no_skip: got %b want 0", ctl);
            bad++;
        end
        reset = 1'b1;
        cycle();
        total++;
        if (ctl !== 9'b0 || retired !== 16'd0) begin
            $display("[TB] FAIL mid_after: got ctl=%b ret=%0d want ctl=0 ret=0", ctl, retired);
            bad++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        run2    = 1'b1;
        opcode2 = 6'b010100;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (pc_we2 !== 1'b1 || we2 !== 1'b1) begin
                $display("[TB] FAIL sat_exec_%0d: got pc_we=%b we=%b want 1 1", i, pc_we2, we2);
                bad++;
            end
            cycle();
            total++;
            if (retired2 !== exp_sat[i]) begin
                $display("[TB] FAIL sat_count_%0d: got %0d want %0d", i, retired2, exp_sat[i]);
                bad++;
            end
        end
        run2 = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_ret = 0;
        test_reset();
        test_li();
        test_alu_jr();
        test_skip(6'b100001, 1'b0, 1'b0, 1'b1, "skipne_z0");
        test_skip(6'b100001, 1'b1, 1'b0, 1'b0, "skipne_z1");
        test_skip(6'b100010, 1'b0, 1'b1, 1'b0, "skipgt_c1");
        test_skip(6'b100010, 1'b0, 1'b0, 1'b1, "skipgt_c0");
        test_skip(6'b100011, 1'b0, 1'b1, 1'b1, "skiplt");
        test_skip(6'b100000, 1'b1, 1'b0, 1'b1, "skipeq");
        test_idle();
        test_halt();
        test_reset_mid_cmp();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
